// File: rtl/lvds_tx_lane_mapper_pkg.sv
// Shared constants, FSM encoding and lane-count helper for the LVDS transmit lane mapper.
package lvds_tx_pkg;

    localparam logic [6:0] CLK_LANE_PAT = 7'b1100011;
    localparam logic [6:0] TRAIN_PAT    = 7'b1010101;

    typedef enum logic {
        S_TRAIN = 1'b0,
        S_VIDEO = 1'b1
    } state_e;

    // 6-bit colour fits in three data lanes; 8-bit needs a fourth for the MSB/LSB pairs.
    function automatic int lane_count(input int color_bits);
        return (color_bits == 6) ? 3 : 4;
    endfunction

endpackage

// File: rtl/lvds_tx_lane_mapper_if.sv
// Pixel-in / lane-word-out bundle between the video source and the lane mapper.
interface lvds_tx_lane_mapper_if #(
    parameter int N_CH       = 2,
    parameter int COLOR_BITS = 8
);
    localparam int L = lvds_tx_pkg::lane_count(COLOR_BITS);

    logic [N_CH*COLOR_BITS-1:0] I_r;
    logic [N_CH*COLOR_BITS-1:0] I_g;
    logic [N_CH*COLOR_BITS-1:0] I_b;
    logic                       I_hs;
    logic                       I_vs;
    logic                       I_de;
    logic                       I_map_jeida;
    logic                       I_swap;
    logic                       I_train_req;
    logic [N_CH*(L+1)*7-1:0]    O_lane_data;
    logic                       O_link_up;

    modport master (
        output I_r, I_g, I_b, I_hs, I_vs, I_de, I_map_jeida, I_swap, I_train_req,
        input  O_lane_data, O_link_up
    );

    modport slave (
        input  I_r, I_g, I_b, I_hs, I_vs, I_de, I_map_jeida, I_swap, I_train_req,
        output O_lane_data, O_link_up
    );

endinterface

// File: rtl/lvds_tx_lane_mapper_pixel_map.sv
// Combinational map of one pixel plus syncs onto its 7-bit data-lane words (bit 6 leaves first).
module lvds_tx_pixel_map
    import lvds_tx_pkg::*;
#(
    parameter  int COLOR_BITS = 8,
    localparam int L          = lane_count(COLOR_BITS)
) (
    input  logic [COLOR_BITS-1:0] r,
    input  logic [COLOR_BITS-1:0] g,
    input  logic [COLOR_BITS-1:0] b,
    input  logic                  hs,
    input  logic                  vs,
    input  logic                  de,
    input  logic                  jeida,
    output logic [L-1:0][6:0]     lanes
);

    generate
        if (COLOR_BITS == 6) begin : g_6b
            always_comb begin
                lanes[0] = {g[0], r[5:0]};
                lanes[1] = {b[1:0], g[5:1]};
                lanes[2] = {de, vs, hs, b[5:2]};
            end
        end else begin : g_8b
            // JEIDA carries the six MSBs where VESA carries the six LSBs; lane 3 takes the leftovers.
            always_comb begin
                if (jeida) begin
                    lanes[0] = {g[2], r[7:2]};
                    lanes[1] = {b[3:2], g[7:3]};
                    lanes[2] = {de, vs, hs, b[7:4]};
                    lanes[3] = {1'b0, b[1:0], g[1:0], r[1:0]};
                end else begin
                    lanes[0] = {g[0], r[5:0]};
                    lanes[1] = {b[1:0], g[5:1]};
                    lanes[2] = {de, vs, hs, b[5:2]};
                    lanes[3] = {1'b0, b[7:6], g[7:6], r[7:6]};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/lvds_tx_lane_mapper.sv
// Two-stage pixel-to-lane mapper with channel swap, blank suppression and link-training sequencer.
module lvds_tx_lane_mapper
    import lvds_tx_pkg::*;
#(
    parameter int N_CH         = 2,
    parameter int COLOR_BITS   = 8,
    parameter int TRAIN_CYCLES = 1024
) (
    input logic                  I_clk_1x,
    input logic                  I_rst_n,
    lvds_tx_lane_mapper_if.slave bus
);

    localparam int L  = lane_count(COLOR_BITS);
    localparam int CW = $clog2(TRAIN_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TRAIN_CYCLES - 1);

    typedef logic [N_CH-1:0][COLOR_BITS-1:0] pix_t;

    // Stage 1: registered, blanked, swapped pixels
    pix_t r1_d, r1_q, g1_d, g1_q, b1_d, b1_q;
    logic hs1_q, vs1_q, de1_q, jeida1_q;

    // Stage 2: lane words and link status
    logic [N_CH-1:0][L-1:0][6:0] map_lanes;
    logic [N_CH-1:0][L:0][6:0]   lane_d, lane_q;
    logic                        link_up_d, link_up_q;

    state_e          state_d, state_q;
    logic [CW-1:0]   cnt_d, cnt_q;

    always_comb begin
        r1_d = '0;
        g1_d = '0;
        b1_d = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (bus.I_de) begin
                r1_d[c] = bus.I_r[(bus.I_swap ? N_CH-1-c : c)*COLOR_BITS +: COLOR_BITS];
                g1_d[c] = bus.I_g[(bus.I_swap ? N_CH-1-c : c)*COLOR_BITS +: COLOR_BITS];
                b1_d[c] = bus.I_b[(bus.I_swap ? N_CH-1-c : c)*COLOR_BITS +: COLOR_BITS];
            end
        end
    end

    always_ff @(posedge I_clk_1x) begin
        if (!I_rst_n) begin
            r1_q      <= '0;
            g1_q      <= '0;
            b1_q      <= '0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            de1_q     <= 1'b0;
            jeida1_q  <= 1'b0;
            lane_q    <= '0;
            link_up_q <= 1'b0;
        end else begin
            r1_q      <= r1_d;
            g1_q      <= g1_d;
            b1_q      <= b1_d;
            hs1_q     <= bus.I_hs;
            vs1_q     <= bus.I_vs;
            de1_q     <= bus.I_de;
            jeida1_q  <= bus.I_map_jeida;
            lane_q    <= lane_d;
            link_up_q <= link_up_d;
        end
    end

    genvar gc;
    generate
        for (gc = 0; gc < N_CH; gc++) begin : g_ch
            lvds_tx_pixel_map #(.COLOR_BITS(COLOR_BITS)) u_map (
                .r     (r1_q[gc]),
                .g     (g1_q[gc]),
                .b     (b1_q[gc]),
                .hs    (hs1_q),
                .vs    (vs1_q),
                .de    (de1_q),
                .jeida (jeida1_q),
                .lanes (map_lanes[gc])
            );
        end
    endgenerate

    always_ff @(posedge I_clk_1x) begin
        if (!I_rst_n) begin
            state_q <= S_TRAIN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A request during training restarts the count, stretching the burst.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_TRAIN) begin
            if (bus.I_train_req) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = S_VIDEO;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (bus.I_train_req) begin
            state_d = S_TRAIN;
            cnt_d   = '0;
        end
    end

    // State selects the word being registered now, so pipeline contents never delay a switch.
    always_comb begin
        lane_d    = '0;
        link_up_d = (state_q == S_VIDEO);
        for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < L; k++) begin
                lane_d[c][k] = (state_q == S_TRAIN) ? TRAIN_PAT : map_lanes[c][k];
            end
            lane_d[c][L] = CLK_LANE_PAT;
        end
    end

    assign bus.O_lane_data = lane_q;
    assign bus.O_link_up   = link_up_q;

endmodule
